// File: rtl/mem_arbiter_if.sv
// Bundles the datapath-side request/response signals and the RAM-side
// strobes into one interface. The arbiter uses the slave view; the
// datapath/RAM environment uses the master view.
interface mem_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic          iREN;
    logic [AW-1:0] iaddr;
    logic          dREN;
    logic          dWEN;
    logic [AW-1:0] daddr;
    logic [DW-1:0] dstore;
    logic          ihit;
    logic [DW-1:0] iload;
    logic          dhit;
    logic [DW-1:0] dload;
    logic          ramREN;
    logic          ramWEN;
    logic [AW-1:0] ramaddr;
    logic [DW-1:0] ramstore;
    logic [DW-1:0] ramload;
    logic [1:0]    ramstate;
    logic          fault;

    modport slave (
        input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
        output ihit, iload, dhit, dload, ramREN, ramWEN, ramaddr, ramstore, fault
    );

    modport master (
        output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
        input  ihit, iload, dhit, dload, ramREN, ramWEN, ramaddr, ramstore, fault
    );
endinterface

// File: rtl/mem_arbiter.sv
// Instruction/data arbiter in front of a single-ported RAM.
// Data requests win over instruction fetches; the granted request is latched
// and held on the RAM port until ACCESS, then a one-cycle hit is returned.
// A stall watchdog or a RAM ERROR parks the block in a sticky FAULT state.
//
// state | meaning
// IDLE  | waiting for a request; data beats instruction
// DATA  | latched data read/write on the RAM port, waiting for ACCESS
// INST  | latched instruction read on the RAM port, waiting for ACCESS
// RESP  | one-cycle ihit/dhit; requester drops its request at this edge
// FAULT | sticky error, strobes and hits low, only nRST leaves
module mem_arbiter #(
    parameter int TIMEOUT = 64,
    parameter int AW      = 32,
    parameter int DW      = 32
) (
    input  logic         CLK,
    input  logic         nRST,
    mem_arbiter_if.slave bus
);
    localparam int WW = $clog2(TIMEOUT + 1);
    localparam logic [WW-1:0] WMAX = WW'(TIMEOUT);
    localparam logic [1:0] RAM_ACCESS = 2'd2;
    localparam logic [1:0] RAM_ERROR  = 2'd3;

    typedef enum logic [2:0] {IDLE, DATA, INST, RESP, FAULT} state_t;

    state_t        state_q;
    logic [WW-1:0] wcnt_q;
    logic [WW-1:0] wcnt_d;
    logic          ihit_q;
    logic          dhit_q;
    logic [DW-1:0] iload_q;
    logic [DW-1:0] dload_q;
    logic          ramREN_q;
    logic          ramWEN_q;
    logic [AW-1:0] ramaddr_q;
    logic [DW-1:0] ramstore_q;
    logic          fault_q;

    // Saturating wait count; the FAULT transition fires before it could wrap.
    assign wcnt_d = (wcnt_q == WMAX) ? wcnt_q : wcnt_q + WW'(1);

    // Arbitration FSM with registered RAM strobes, latched request and hits.
    // ramWEN_q doubles as the latched operation for the whole DATA dwell.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q    <= IDLE;
            wcnt_q     <= '0;
            ihit_q     <= 1'b0;
            dhit_q     <= 1'b0;
            iload_q    <= '0;
            dload_q    <= '0;
            ramREN_q   <= 1'b0;
            ramWEN_q   <= 1'b0;
            ramaddr_q  <= '0;
            ramstore_q <= '0;
            fault_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    ihit_q <= 1'b0;
                    dhit_q <= 1'b0;
                    if (bus.dREN || bus.dWEN) begin
                        state_q    <= DATA;
                        wcnt_q     <= '0;
                        ramaddr_q  <= bus.daddr;
                        ramstore_q <= bus.dstore;
                        ramWEN_q   <= bus.dWEN;
                        ramREN_q   <= ~bus.dWEN;
                    end else if (bus.iREN) begin
                        state_q   <= INST;
                        wcnt_q    <= '0;
                        ramaddr_q <= bus.iaddr;
                        ramWEN_q  <= 1'b0;
                        ramREN_q  <= 1'b1;
                    end
                end
                DATA, INST: begin
                    if (bus.ramstate == RAM_ACCESS) begin
                        state_q  <= RESP;
                        ramREN_q <= 1'b0;
                        ramWEN_q <= 1'b0;
                        if (state_q == INST) begin
                            iload_q <= bus.ramload;
                            ihit_q  <= 1'b1;
                        end else begin
                            dhit_q <= 1'b1;
                            if (!ramWEN_q) begin
                                dload_q <= bus.ramload;
                            end
                        end
                    end else if (bus.ramstate == RAM_ERROR || wcnt_d == WMAX) begin
                        state_q  <= FAULT;
                        wcnt_q   <= wcnt_d;
                        ramREN_q <= 1'b0;
                        ramWEN_q <= 1'b0;
                        fault_q  <= 1'b1;
                    end else begin
                        wcnt_q <= wcnt_d;
                    end
                end
                RESP: begin
                    state_q <= IDLE;
                    ihit_q  <= 1'b0;
                    dhit_q  <= 1'b0;
                end
                FAULT: begin
                    ihit_q   <= 1'b0;
                    dhit_q   <= 1'b0;
                    ramREN_q <= 1'b0;
                    ramWEN_q <= 1'b0;
                    fault_q  <= 1'b1;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.ihit     = ihit_q;
    assign bus.dhit     = dhit_q;
    assign bus.iload    = iload_q;
    assign bus.dload    = dload_q;
    assign bus.ramREN   = ramREN_q;
    assign bus.ramWEN   = ramWEN_q;
    assign bus.ramaddr  = ramaddr_q;
    assign bus.ramstore = ramstore_q;
    assign bus.fault    = fault_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: reset, fetch, data priority, write hold,
// request hold, stall timeout, RAM error and reset during a transaction.
module tb_mem_arbiter;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam logic [1:0] FREE   = 2'd0;
    localparam logic [1:0] BUSY   = 2'd1;
    localparam logic [1:0] ACCESS = 2'd2;
    localparam logic [1:0] ERROR  = 2'd3;

    logic CLK = 1'b0;
    logic nRST;

    mem_arbiter_if #(.AW(AW), .DW(DW)) bus ();

    mem_arbiter #(.TIMEOUT(4), .AW(AW), .DW(DW)) dut (
        .CLK  (CLK),
        .nRST (nRST),
        .bus  (bus.slave)
    );

    always #5 CLK = ~CLK;

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;

    int dhit_cnt    = 0;
    int ihit_cnt    = 0;
    int overlap_cnt = 0;
    int txn_cnt     = 0;
    logic strobe_prev = 1'b0;

    always @(negedge CLK) begin
        if (bus.dhit === 1'b1) dhit_cnt++;
        if (bus.ihit === 1'b1) ihit_cnt++;
        if (bus.dhit === 1'b1 && bus.ihit === 1'b1) overlap_cnt++;
        if ((bus.ramREN | bus.ramWEN) === 1'b1 && !strobe_prev) txn_cnt++;
        strobe_prev = ((bus.ramREN | bus.ramWEN) === 1'b1);
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        bus.iREN     = 1'b0;
        bus.iaddr    = '0;
        bus.dREN     = 1'b0;
        bus.dWEN     = 1'b0;
        bus.daddr    = '0;
        bus.dstore   = '0;
        bus.ramload  = '0;
        bus.ramstate = FREE;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ihit"},     32'(bus.ihit),   32'd0);
        check({tag, "_dhit"},     32'(bus.dhit),   32'd0);
        check({tag, "_ramREN"},   32'(bus.ramREN), 32'd0);
        check({tag, "_ramWEN"},   32'(bus.ramWEN), 32'd0);
        check({tag, "_fault"},    32'(bus.fault),  32'd0);
        check({tag, "_iload"},    bus.iload,       32'd0);
        check({tag, "_dload"},    bus.dload,       32'd0);
        check({tag, "_ramaddr"},  bus.ramaddr,     32'd0);
        check({tag, "_ramstore"}, bus.ramstore,    32'd0);
    endtask

    int d0;
    int t0;

    initial begin
        // reset with random inputs
        nRST         = 1'b0;
        bus.iREN     = 1'($urandom);
        bus.iaddr    = $urandom;
        bus.dREN     = 1'($urandom);
        bus.dWEN     = 1'($urandom);
        bus.daddr    = $urandom;
        bus.dstore   = $urandom;
        bus.ramload  = $urandom;
        bus.ramstate = 2'($urandom_range(0, 3));
        tick();
        tick();
        check_all_zero("rst");

        // first fetch straight out of reset, zero-wait RAM
        idle_inputs();
        bus.iREN     = 1'b1;
        bus.iaddr    = 32'h40;
        bus.ramstate = ACCESS;
        bus.ramload  = 32'h8C010004;
        nRST = 1'b1;
        tick();
        check("fetch_ramREN",  32'(bus.ramREN), 32'd1);
        check("fetch_ramaddr", bus.ramaddr,     32'h40);
        check("fetch_ihit_early", 32'(bus.ihit), 32'd0);
        bus.iREN = 1'b0;
        tick();
        check("fetch_ihit",   32'(bus.ihit),   32'd1);
        check("fetch_iload",  bus.iload,       32'h8C010004);
        check("fetch_ramREN_off", 32'(bus.ramREN), 32'd0);
        tick();
        check("fetch_ihit_pulse", 32'(bus.ihit), 32'd0);

        // simultaneous iREN and dREN: data first, 3 BUSY cycles
        idle_inputs();
        bus.iREN     = 1'b1;
        bus.iaddr    = 32'h44;
        bus.dREN     = 1'b1;
        bus.daddr    = 32'h100;
        bus.ramstate = BUSY;
        tick();
        check("prio_ramREN",  32'(bus.ramREN), 32'd1);
        check("prio_ramaddr", bus.ramaddr,     32'h100);
        tick();
        tick();
        tick();
        check("prio_wait_ramREN", 32'(bus.ramREN), 32'd1);
        check("prio_wait_dhit",   32'(bus.dhit),   32'd0);
        bus.ramstate = ACCESS;
        bus.ramload  = 32'hDEADBEEF;
        tick();
        check("prio_dhit",  32'(bus.dhit), 32'd1);
        check("prio_ihit",  32'(bus.ihit), 32'd0);
        check("prio_dload", bus.dload,     32'hDEADBEEF);
        bus.dREN    = 1'b0;
        bus.ramload = 32'hCAFEF00D;
        tick();
        check("prio_resp_dhit", 32'(bus.dhit),   32'd0);
        check("prio_resp_ramREN", 32'(bus.ramREN), 32'd0);
        tick();
        check("prio_inst_ramREN",  32'(bus.ramREN), 32'd1);
        check("prio_inst_ramaddr", bus.ramaddr,     32'h44);
        bus.iREN = 1'b0;
        tick();
        check("prio_inst_ihit",  32'(bus.ihit), 32'd1);
        check("prio_inst_dhit",  32'(bus.dhit), 32'd0);
        check("prio_inst_iload", bus.iload,     32'hCAFEF00D);
        tick();

        // write with store data changing mid-transaction
        idle_inputs();
        bus.dWEN     = 1'b1;
        bus.dREN     = 1'b1;
        bus.daddr    = 32'h200;
        bus.dstore   = 32'h12345678;
        bus.ramstate = BUSY;
        tick();
        check("wr_ramWEN",   32'(bus.ramWEN), 32'd1);
        check("wr_ramREN",   32'(bus.ramREN), 32'd0);
        check("wr_ramaddr",  bus.ramaddr,     32'h200);
        check("wr_ramstore", bus.ramstore,    32'h12345678);
        bus.dstore = 32'hFFFFFFFF;
        bus.daddr  = 32'h0;
        tick();
        check("wr_hold_ramstore", bus.ramstore, 32'h12345678);
        check("wr_hold_ramaddr",  bus.ramaddr,  32'h200);
        tick();
        check("wr_hold2_ramstore", bus.ramstore, 32'h12345678);
        check("wr_hold2_ramWEN",   32'(bus.ramWEN), 32'd1);
        bus.ramstate = ACCESS;
        bus.ramload  = 32'h55555555;
        d0 = dhit_cnt;
        tick();
        check("wr_dhit",   32'(bus.dhit), 32'd1);
        check("wr_dload",  bus.dload,     32'hDEADBEEF);
        check("wr_ramWEN_off", 32'(bus.ramWEN), 32'd0);
        bus.dWEN = 1'b0;
        bus.dREN = 1'b0;
        tick();
        tick();
        check("wr_one_dhit", 32'(dhit_cnt - d0), 32'd1);

        // request held through dhit, dropped at the following edge
        idle_inputs();
        d0 = dhit_cnt;
        t0 = txn_cnt;
        bus.dREN     = 1'b1;
        bus.daddr    = 32'h300;
        bus.ramstate = ACCESS;
        bus.ramload  = 32'h11112222;
        tick();
        check("hold_ramREN", 32'(bus.ramREN), 32'd1);
        tick();
        check("hold_dhit",  32'(bus.dhit), 32'd1);
        check("hold_dload", bus.dload,     32'h11112222);
        tick();
        bus.dREN = 1'b0;
        tick();
        tick();
        tick();
        check("hold_dhit_count", 32'(dhit_cnt - d0), 32'd1);
        check("hold_txn_count",  32'(txn_cnt - t0),  32'd1);

        // stall watchdog with TIMEOUT = 4
        idle_inputs();
        bus.dREN     = 1'b1;
        bus.daddr    = 32'h400;
        bus.ramstate = BUSY;
        tick();
        bus.dREN = 1'b0;
        check("to_ramREN", 32'(bus.ramREN), 32'd1);
        tick();
        tick();
        tick();
        check("to_fault_before", 32'(bus.fault),  32'd0);
        check("to_ramREN_before", 32'(bus.ramREN), 32'd1);
        tick();
        check("to_fault",  32'(bus.fault),  32'd1);
        check("to_ramREN_off", 32'(bus.ramREN), 32'd0);
        bus.iREN     = 1'b1;
        bus.dWEN     = 1'b1;
        bus.ramstate = ACCESS;
        tick();
        tick();
        tick();
        check("to_sticky_fault",  32'(bus.fault),  32'd1);
        check("to_sticky_ramREN", 32'(bus.ramREN), 32'd0);
        check("to_sticky_ramWEN", 32'(bus.ramWEN), 32'd0);
        check("to_sticky_hits",   32'({bus.ihit, bus.dhit}), 32'd0);
        nRST = 1'b0;
        #1;
        check("to_rst_fault", 32'(bus.fault), 32'd0);
        idle_inputs();
        tick();
        nRST = 1'b1;

        // RAM ERROR during an instruction fetch
        bus.iREN     = 1'b1;
        bus.iaddr    = 32'h80;
        bus.ramstate = BUSY;
        tick();
        check("err_ramREN", 32'(bus.ramREN), 32'd1);
        bus.iREN     = 1'b0;
        bus.ramstate = ERROR;
        tick();
        check("err_fault",  32'(bus.fault),  32'd1);
        check("err_ramREN_off", 32'(bus.ramREN), 32'd0);
        check("err_ihit",   32'(bus.ihit),   32'd0);
        nRST = 1'b0;
        idle_inputs();
        tick();
        nRST = 1'b1;

        // reset asserted in the middle of a BUSY data read
        bus.dREN     = 1'b1;
        bus.daddr    = 32'h500;
        bus.ramstate = BUSY;
        tick();
        check("midrst_ramREN", 32'(bus.ramREN), 32'd1);
        tick();
        d0 = dhit_cnt;
        nRST = 1'b0;
        #1;
        check_all_zero("midrst");
        bus.dREN     = 1'b0;
        bus.ramstate = ACCESS;
        tick();
        nRST = 1'b1;
        tick();
        tick();
        tick();
        check("midrst_no_dhit", 32'(dhit_cnt - d0), 32'd0);
        check("midrst_idle_ramREN", 32'(bus.ramREN), 32'd0);

        check("no_hit_overlap", 32'(overlap_cnt), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
